single_event_unpacker: RTL and testbench

Backend-side consumer of the front-end single-event stream. Pops 128-bit event words and their 48-bit start-period tags from the front-end output FIFO using a valid/ready handshake. Validates framing and unpacks the fields. Inserts a time-tag word into the output stream whenever the period changes, so downstream logic sees tags ahead of the events they govern.

---
 rtl/single_event_unpacker_if.sv | 37 +++
 rtl/single_event_unpacker.sv | 173 +++++++++++++++++
 tb/tb_single_event_unpacker.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/single_event_unpacker_if.sv
// Handshake and status bundle for the single-event unpacker.
//   slave  : the unpacker itself (pops the front-end FIFO, drives the output stream)
//   master : the environment (front-end FIFO + downstream consumer)
// Input side : in_valid, in_ready, in_data, in_period
// Output side: out_valid, out_ready, out_data, out_is_tag, out_id, out_energy_sum
// Status     : err_framing, err_count
interface single_event_unpacker_if #(
   parameter int unsigned DATA_BITS   = 128,
   parameter int unsigned ID_BITS     = 6,
   parameter int unsigned PERIOD_BITS = 48,
   parameter int unsigned SUM_BITS    = 15
);
   logic                   in_valid;
   logic                   in_ready;
   logic [DATA_BITS-1:0]   in_data;
   logic [PERIOD_BITS-1:0] in_period;
   logic                   out_valid;
   logic                   out_ready;
   logic [DATA_BITS-1:0]   out_data;
   logic                   out_is_tag;
   logic [ID_BITS-1:0]     out_id;
   logic [SUM_BITS-1:0]    out_energy_sum;
   logic                   err_framing;
   logic [15:0]            err_count;

   modport slave (
      input  in_valid, in_data, in_period, out_ready,
      output in_ready, out_valid, out_data, out_is_tag, out_id, out_energy_sum,
      output err_framing, err_count
   );

   modport master (
      output in_valid, in_data, in_period, out_ready,
      input  in_ready, out_valid, out_data, out_is_tag, out_id, out_energy_sum,
      input  err_framing, err_count
   );
endinterface

// File: rtl/single_event_unpacker.sv
// Backend consumer of the front-end single-event stream. Pops event words with their start
// period, drops malformed words (counting them), and emits a time-tag word ahead of any event
// whose period differs from the previous one.
// Ports:
//   clk  : backend clock
//   rst  : asynchronous reset, active-low
//   bus  : single_event_unpacker_if.slave (input FIFO pop, output stream, error status)
module single_event_unpacker #(
   parameter int unsigned DATA_BITS    = 128,
   parameter int unsigned ID_BITS      = 6,
   parameter int unsigned NCHAN_ENERGY = 8,
   parameter int unsigned COUNTER_BITS = 12,
   parameter int unsigned TIME_BITS    = 20,
   parameter int unsigned PERIOD_BITS  = 48,
   parameter int unsigned CRC_BITS     = 5
) (
   input logic                    clk,
   input logic                    rst,
   single_event_unpacker_if.slave bus
);
   localparam int unsigned SumBits = COUNTER_BITS + $clog2(NCHAN_ENERGY);
   localparam int unsigned FlagPos = DATA_BITS - CRC_BITS - 1;
   localparam int unsigned IdTop   = FlagPos - 1;

   typedef enum logic [0:0] {StIdle, StPend} state_e;

   state_e                 state_q, state_d;
   logic                   out_valid_q, out_valid_d;
   logic [DATA_BITS-1:0]   out_data_q, out_data_d;
   logic                   out_is_tag_q, out_is_tag_d;
   logic [ID_BITS-1:0]     out_id_q, out_id_d;
   logic [SumBits-1:0]     out_sum_q, out_sum_d;
   logic [DATA_BITS-1:0]   pend_data_q, pend_data_d;
   logic [ID_BITS-1:0]     pend_id_q, pend_id_d;
   logic [SumBits-1:0]     pend_sum_q, pend_sum_d;
   logic                   have_period_q, have_period_d;
   logic [PERIOD_BITS-1:0] last_period_q, last_period_d;
   logic                   err_framing_q, err_framing_d;
   logic [15:0]            err_count_q, err_count_d;

   logic                   in_ready;
   logic                   accept;
   logic                   frame_ok;
   logic                   need_tag;
   logic [ID_BITS-1:0]     in_id;
   logic [SumBits-1:0]     in_sum;
   logic [DATA_BITS-1:0]   tag_word;

   assign in_ready = (state_q == StIdle) && (!out_valid_q || bus.out_ready);
   assign accept   = bus.in_valid && in_ready;
   assign frame_ok = (bus.in_data[DATA_BITS-1 -: CRC_BITS] == {CRC_BITS{1'b1}}) &&
                     bus.in_data[FlagPos];
   assign need_tag = !have_period_q || (bus.in_period != last_period_q);
   assign in_id    = bus.in_data[IdTop -: ID_BITS];

   always_comb begin
      in_sum = '0;
      for (int k = 0; k < int'(NCHAN_ENERGY); k++) begin
         in_sum = in_sum + SumBits'(bus.in_data[TIME_BITS + k*COUNTER_BITS +: COUNTER_BITS]);
      end
   end

   // Tag word: framing ones, flag clear, period in the low bits.
   always_comb begin
      tag_word                             = '0;
      tag_word[DATA_BITS-1 -: CRC_BITS]    = '1;
      tag_word[PERIOD_BITS-1:0]            = bus.in_period;
   end

   always_comb begin
      state_d       = state_q;
      out_valid_d   = out_valid_q;
      out_data_d    = out_data_q;
      out_is_tag_d  = out_is_tag_q;
      out_id_d      = out_id_q;
      out_sum_d     = out_sum_q;
      pend_data_d   = pend_data_q;
      pend_id_d     = pend_id_q;
      pend_sum_d    = pend_sum_q;
      have_period_d = have_period_q;
      last_period_d = last_period_q;
      err_framing_d = 1'b0;
      err_count_d   = err_count_q;

      if (out_valid_q && bus.out_ready) begin
         out_valid_d = 1'b0;
      end

      unique case (state_q)
         StIdle: begin
            if (accept) begin
               if (!frame_ok) begin
                  err_framing_d = 1'b1;
                  if (err_count_q != 16'hFFFF) begin
                     err_count_d = err_count_q + 16'd1;
                  end
               end else if (need_tag) begin
                  out_valid_d   = 1'b1;
                  out_data_d    = tag_word;
                  out_is_tag_d  = 1'b1;
                  out_id_d      = '0;
                  out_sum_d     = '0;
                  pend_data_d   = bus.in_data;
                  pend_id_d     = in_id;
                  pend_sum_d    = in_sum;
                  last_period_d = bus.in_period;
                  have_period_d = 1'b1;
                  state_d       = StPend;
               end else begin
                  out_valid_d  = 1'b1;
                  out_data_d   = bus.in_data;
                  out_is_tag_d = 1'b0;
                  out_id_d     = in_id;
                  out_sum_d    = in_sum;
               end
            end
         end
         StPend: begin
            // The tag is always valid here; release the held event once it is consumed.
            if (out_valid_q && bus.out_ready) begin
               out_valid_d  = 1'b1;
               out_data_d   = pend_data_q;
               out_is_tag_d = 1'b0;
               out_id_d     = pend_id_q;
               out_sum_d    = pend_sum_q;
               state_d      = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q       <= StIdle;
         out_valid_q   <= 1'b0;
         out_data_q    <= '0;
         out_is_tag_q  <= 1'b0;
         out_id_q      <= '0;
         out_sum_q     <= '0;
         pend_data_q   <= '0;
         pend_id_q     <= '0;
         pend_sum_q    <= '0;
         have_period_q <= 1'b0;
         last_period_q <= '0;
         err_framing_q <= 1'b0;
         err_count_q   <= '0;
      end else begin
         state_q       <= state_d;
         out_valid_q   <= out_valid_d;
         out_data_q    <= out_data_d;
         out_is_tag_q  <= out_is_tag_d;
         out_id_q      <= out_id_d;
         out_sum_q     <= out_sum_d;
         pend_data_q   <= pend_data_d;
         pend_id_q     <= pend_id_d;
         pend_sum_q    <= pend_sum_d;
         have_period_q <= have_period_d;
         last_period_q <= last_period_d;
         err_framing_q <= err_framing_d;
         err_count_q   <= err_count_d;
      end
   end

   assign bus.in_ready       = in_ready;
   assign bus.out_valid      = out_valid_q;
   assign bus.out_data       = out_data_q;
   assign bus.out_is_tag     = out_is_tag_q;
   assign bus.out_id         = out_id_q;
   assign bus.out_energy_sum = out_sum_q;
   assign bus.err_framing    = err_framing_q;
   assign bus.err_count      = err_count_q;
endmodule

// File: tb/tb_single_event_unpacker.sv
module tb_single_event_unpacker;
   logic clk;
   logic rst;

   single_event_unpacker_if bus ();

   single_event_unpacker dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [127:0] data;
      logic         tag;
      logic [5:0]   id;
      logic [14:0]  sum;
   } out_t;

   typedef struct {
      logic [127:0] data;
      logic [47:0]  period;
      logic         exp_tag;
      int           exp_wait;
      logic [5:0]   id;
      logic [14:0]  sum;
   } vec_t;

   out_t got[$];
   out_t expq[$];
   vec_t vecs[5];

   int n_checks = 0;
   int n_pass   = 0;

   always @(negedge clk) begin
      if (rst && bus.out_valid && bus.out_ready) begin
         got.push_back('{data: bus.out_data, tag: bus.out_is_tag, id: bus.out_id,
                         sum: bus.out_energy_sum});
      end
   end

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   function automatic logic [127:0] mk(input logic [4:0] fr, input logic fl, input logic [5:0] id,
                                       input logic [95:0] en, input logic [19:0] t);
      return {fr, fl, id, en, t};
   endfunction

   function automatic logic [127:0] mk_tag(input logic [47:0] p);
      return {5'h1F, 1'b0, 74'b0, p};
   endfunction

   // Called aligned to posedge+1; returns aligned to 1 unit after the accepting edge.
   task automatic push(input logic [127:0] d, input logic [47:0] p, output int waits);
      bus.in_valid  = 1'b1;
      bus.in_data   = d;
      bus.in_period = p;
      waits = 0;
      while (!bus.in_ready && waits < 50) begin
         @(posedge clk);
         #1;
         waits++;
      end
      if (!bus.in_ready) begin
         n_checks++;
         $display("FAIL push_timeout: in_ready stuck low, required 1");
      end else begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic cycles(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      int w;
      logic [127:0] bad1, bad2, ev;

      vecs[0] = '{data: mk(5'h1F, 1'b1, 6'h2A, {8{12'h001}}, 20'h12345), period: 48'h10,
                  exp_tag: 1'b1, exp_wait: 0, id: 6'h2A, sum: 15'd8};
      vecs[1] = '{data: mk(5'h1F, 1'b1, 6'h01, {12'd8, 12'd7, 12'd6, 12'd5, 12'd4, 12'd3,
                  12'd2, 12'd1}, 20'h00001), period: 48'h10,
                  exp_tag: 1'b0, exp_wait: 1, id: 6'h01, sum: 15'd36};
      vecs[2] = '{data: mk(5'h1F, 1'b1, 6'h3F, {8{12'hFFF}}, 20'hFFFFF), period: 48'h10,
                  exp_tag: 1'b0, exp_wait: 0, id: 6'h3F, sum: 15'h7FF8};
      vecs[3] = '{data: mk(5'h1F, 1'b1, 6'h05, 96'h0, 20'h00ABC), period: 48'h11,
                  exp_tag: 1'b1, exp_wait: 0, id: 6'h05, sum: 15'd0};
      vecs[4] = '{data: mk(5'h1F, 1'b1, 6'h10, {8{12'h100}}, 20'h00002), period: 48'h05,
                  exp_tag: 1'b1, exp_wait: 1, id: 6'h10, sum: 15'h0800};

      rst           = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.in_period = '0;
      bus.out_ready = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk) rst = 1'b1;
      cycles(1);

      // Reset state
      chk("rst_out_valid", 128'(bus.out_valid), 128'd0);
      chk("rst_out_data", bus.out_data, 128'd0);
      chk("rst_out_is_tag", 128'(bus.out_is_tag), 128'd0);
      chk("rst_out_id", 128'(bus.out_id), 128'd0);
      chk("rst_out_sum", 128'(bus.out_energy_sum), 128'd0);
      chk("rst_err_framing", 128'(bus.err_framing), 128'd0);
      chk("rst_err_count", 128'(bus.err_count), 128'd0);
      chk("rst_in_ready", 128'(bus.in_ready), 128'd1);

      // Table: tags, same-period throughput, period increase and decrease
      for (int i = 0; i < 5; i++) begin
         push(vecs[i].data, vecs[i].period, w);
         chk($sformatf("vec%0d_wait", i), 128'(w), 128'(vecs[i].exp_wait));
         if (vecs[i].exp_tag)
            expq.push_back('{data: mk_tag(vecs[i].period), tag: 1'b1, id: 6'h0, sum: 15'h0});
         expq.push_back('{data: vecs[i].data, tag: 1'b0, id: vecs[i].id, sum: vecs[i].sum});
      end
      bus.in_valid = 1'b0;
      cycles(4);
      chk("table_count", 128'(got.size()), 128'(expq.size()));
      for (int i = 0; i < expq.size() && i < got.size(); i++) begin
         chk($sformatf("out%0d_data", i), got[i].data, expq[i].data);
         chk($sformatf("out%0d_tag", i), 128'(got[i].tag), 128'(expq[i].tag));
         chk($sformatf("out%0d_id", i), 128'(got[i].id), 128'(expq[i].id));
         chk($sformatf("out%0d_sum", i), 128'(got[i].sum), 128'(expq[i].sum));
      end

      // Malformed words: bad framing, then clear flag
      got.delete();
      bad1 = mk(5'h1E, 1'b1, 6'h01, {8{12'h001}}, 20'h1);
      bad2 = mk(5'h1F, 1'b0, 6'h01, {8{12'h001}}, 20'h1);
      push(bad1, 48'h05, w);
      bus.in_valid = 1'b0;
      chk("bad_framing_pulse", 128'(bus.err_framing), 128'd1);
      chk("bad_framing_count", 128'(bus.err_count), 128'd1);
      cycles(1);
      chk("bad_framing_pulse_end", 128'(bus.err_framing), 128'd0);
      push(bad2, 48'h05, w);
      bus.in_valid = 1'b0;
      chk("bad_flag_count", 128'(bus.err_count), 128'd2);
      for (int i = 0; i < 65533; i++) push(bad1, 48'h05, w);
      bus.in_valid = 1'b0;
      chk("err_count_max", 128'(bus.err_count), 128'hFFFF);
      push(bad1, 48'h05, w);
      bus.in_valid = 1'b0;
      chk("err_count_sat", 128'(bus.err_count), 128'hFFFF);
      chk("err_sat_pulse", 128'(bus.err_framing), 128'd1);
      cycles(2);
      chk("bad_no_output", 128'(got.size()), 128'd0);
      chk("bad_out_valid", 128'(bus.out_valid), 128'd0);

      // Stall: same period (05), all energies max, downstream not ready
      bus.out_ready = 1'b0;
      ev = mk(5'h1F, 1'b1, 6'h3F, {8{12'hFFF}}, 20'h54321);
      push(ev, 48'h05, w);
      bus.in_valid = 1'b0;
      chk("stall_wait", 128'(w), 128'd0);
      chk("stall_sum", 128'(bus.out_energy_sum), 128'h7FF8);
      for (int i = 0; i < 5; i++) begin
         chk($sformatf("stall%0d_valid", i), 128'(bus.out_valid), 128'd1);
         chk($sformatf("stall%0d_data", i), bus.out_data, ev);
         chk($sformatf("stall%0d_in_ready", i), 128'(bus.in_ready), 128'd0);
         cycles(1);
      end
      bus.out_ready = 1'b1;
      cycles(1);
      chk("stall_drain_valid", 128'(bus.out_valid), 128'd0);
      chk("stall_drain_count", 128'(got.size()), 128'd1);
      if (got.size() > 0) chk("stall_drain_data", got[0].data, ev);

      // Reset while a tag is pending
      bus.out_ready = 1'b0;
      ev = mk(5'h1F, 1'b1, 6'h07, {8{12'h002}}, 20'h00777);
      push(ev, 48'h99, w);
      bus.in_valid = 1'b0;
      chk("pend_is_tag", 128'(bus.out_is_tag), 128'd1);
      chk("pend_in_ready", 128'(bus.in_ready), 128'd0);
      #2 rst = 1'b0;
      #1;
      chk("async_rst_valid", 128'(bus.out_valid), 128'd0);
      chk("async_rst_tag", 128'(bus.out_is_tag), 128'd0);
      @(negedge clk) rst = 1'b1;
      cycles(1);
      bus.out_ready = 1'b1;
      got.delete();
      push(ev, 48'h99, w);
      bus.in_valid = 1'b0;
      cycles(3);
      chk("post_rst_count", 128'(got.size()), 128'd2);
      if (got.size() == 2) begin
         chk("post_rst_tag", 128'(got[0].tag), 128'd1);
         chk("post_rst_tag_data", got[0].data, mk_tag(48'h99));
         chk("post_rst_event", got[1].data, ev);
         chk("post_rst_id", 128'(got[1].id), 128'h07);
         chk("post_rst_sum", 128'(got[1].sum), 128'd16);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
